// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST controller and its watchdog.
package lbist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StRun,
    StSettle,
    StCompare,
    StDone
  } state_e;

  localparam int unsigned WdogLimit  = 4;
  localparam int unsigned WdogCntW   = 3;
  localparam int unsigned SettleCntW = 4;

endpackage

// File: rtl/lbist_wdog.sv
// Stall watchdog: flags a pattern counter that stops moving while increments are requested.
module lbist_wdog
  import lbist_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            active,
  input  logic [BITS-1:0] count,
  output logic            expired
);

  logic [BITS-1:0]     last_q;
  logic [WdogCntW-1:0] stall_q;
  logic                same;

  assign same    = (count == last_q);
  // Fires on the WdogLimit-th consecutive stalled cycle so the FSM aborts on that edge.
  assign expired = active && same && (stall_q == WdogCntW'(WdogLimit - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= '0;
      stall_q <= '0;
    end else begin
      last_q <= count;
      if (active && same) begin
        stall_q <= stall_q + 1'b1;
      end else begin
        stall_q <= '0;
      end
    end
  end

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST run controller: seed, run N_PATTERNS, settle, compare signature.
// Optional stall watchdog enabled by defining LBIST_CTRL_TIMEOUT_EN.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned     BITS          = 8,
  parameter int unsigned     N_PATTERNS    = 200,
  parameter int unsigned     SIG_W         = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0,
  parameter int unsigned     SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:BITS-1]  count,
  input  logic [SIG_W-1:0] sig,
  output logic             inc,
  output logic             seed_load,
  output logic             capture_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  state_e                state_q;
  logic [BITS-1:0]       base_q;
  logic [BITS-1:0]       delta;
  logic [SettleCntW-1:0] settle_q;
  logic                  wdog_expire;

  // Modular distance so a base near the top of the counter range still terminates.
  assign delta = count - base_q;
  assign inc   = (state_q == StRun) && (delta != BITS'(N_PATTERNS));

`ifdef LBIST_CTRL_TIMEOUT_EN
  logic timeout_q;

  lbist_wdog #(
    .BITS(BITS)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (inc),
    .count  (count),
    .expired(wdog_expire)
  );

  assign timeout = timeout_q;
`else
  assign wdog_expire = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      settle_q   <= '0;
      seed_load  <= 1'b0;
      capture_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef LBIST_CTRL_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      seed_load <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StSeed;
            seed_load <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef LBIST_CTRL_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        StSeed: begin
          base_q     <= count;
          capture_en <= 1'b1;
          state_q    <= StRun;
        end
        StRun: begin
          if (delta == BITS'(N_PATTERNS)) begin
            settle_q <= '0;
            state_q  <= StSettle;
          end
          // Stall abort; exclusive with the branch above since it needs inc=1.
          if (wdog_expire) begin
            capture_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            state_q    <= StDone;
`ifdef LBIST_CTRL_TIMEOUT_EN
            timeout_q  <= 1'b1;
`endif
          end
        end
        StSettle: begin
          if (settle_q == SettleCntW'(SETTLE_CYCLES - 1)) begin
            capture_en <= 1'b0;
            state_q    <= StCompare;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StCompare: begin
          pass    <= (sig == GOLDEN_SIG);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lbist_ctrl.sv
// Scoreboard bench for lbist_ctrl with a model pattern counter attached.
module tb_lbist_ctrl;

  localparam int unsigned     BITS   = 8;
  localparam int unsigned     NPAT   = 10;
  localparam int unsigned     SETTLE = 2;
  localparam logic [15:0]     GOLDEN = 16'hA5C3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      cnt = '0;
  logic [15:0]     sig = '0;
  logic            inc, seed_load, capture_en, busy, done, pass, timeout;
  logic            ld = 1'b0;
  logic [7:0]      ld_val = '0;
  logic            freeze = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edges;
    int         incs;
    logic [7:0] cnt_end;
    logic       pass;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  lbist_ctrl #(
    .BITS         (BITS),
    .N_PATTERNS   (NPAT),
    .SIG_W        (16),
    .GOLDEN_SIG   (GOLDEN),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (cnt),
    .sig       (sig),
    .inc       (inc),
    .seed_load (seed_load),
    .capture_en(capture_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Model pattern counter.
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (inc && !freeze) cnt <= cnt + 8'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_cnt(input logic [7:0] v);
    ld     = 1'b1;
    ld_val = v;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  // One run: push the expected outcome, pulse (or hold) start, observe until done.
  task automatic run(input string name, input logic [7:0] c0, input logic [15:0] s,
                     input bit hold, input bit stall);
    exp_t e;
    exp_t got_e;
    int   edges, incs, seeds, caps;
    sig = s;
    if (stall) begin
      e.edges = 5; e.incs = 4; e.cnt_end = c0; e.pass = 1'b0; e.tmo = 1'b1;
    end else begin
      e.edges = NPAT + SETTLE + 3; e.incs = NPAT; e.cnt_end = 8'(c0 + 8'(NPAT));
      e.pass = (s == GOLDEN); e.tmo = 1'b0;
    end
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check_eq({name, "_done_clr"}, {31'd0, done}, 32'd0);
    check_eq({name, "_pass_clr"}, {31'd0, pass}, 32'd0);
    edges = 0; incs = 0; seeds = 0; caps = 0;
    while (!done && edges < 100) begin
      incs  += int'(inc);
      seeds += int'(seed_load);
      caps  += int'(capture_en);
      @(posedge clk);
      #1 edges++;
    end
    start = 1'b0;
    got_e = sb.pop_front();
    check_eq({name, "_done"},    {31'd0, done},    32'd1);
    check_eq({name, "_edges"},   edges,            got_e.edges);
    check_eq({name, "_incs"},    incs,             got_e.incs);
    check_eq({name, "_seed"},    seeds,            32'd1);
    check_eq({name, "_cnt"},     {24'd0, cnt},     {24'd0, got_e.cnt_end});
    check_eq({name, "_pass"},    {31'd0, pass},    {31'd0, got_e.pass});
    check_eq({name, "_timeout"}, {31'd0, timeout}, {31'd0, got_e.tmo});
    check_eq({name, "_busy"},    {31'd0, busy},    32'd0);
    if (!stall) check_eq({name, "_capture"}, caps, NPAT + 1 + SETTLE);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_inc",     {31'd0, inc},        32'd0);
    check_eq("rst_seed",    {31'd0, seed_load},  32'd0);
    check_eq("rst_capture", {31'd0, capture_en}, 32'd0);
    check_eq("rst_busy",    {31'd0, busy},       32'd0);
    check_eq("rst_done",    {31'd0, done},       32'd0);
    check_eq("rst_pass",    {31'd0, pass},       32'd0);
    check_eq("rst_timeout", {31'd0, timeout},    32'd0);
    rst = 1'b0;

    load_cnt(8'd0);
    run("pass", 8'd0, 16'hA5C3, 1'b0, 1'b0);
    // Held start in DONE restarts immediately and is ignored while busy.
    load_cnt(8'd0);
    run("held", 8'd0, 16'hA5C3, 1'b1, 1'b0);
    load_cnt(8'd0);
    run("badsig", 8'd0, 16'hA5C2, 1'b0, 1'b0);
    load_cnt(8'd250);
    run("wrap", 8'd250, 16'hA5C3, 1'b0, 1'b0);

    // Mid-run start is ignored; reset in the 5th RUN cycle.
    load_cnt(8'd0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("mid_seed", {31'd0, seed_load}, 32'd0);
    check_eq("mid_busy", {31'd0, busy},      32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("mid_inc5", {31'd0, inc}, 32'd1);
    check_eq("mid_cnt5", {24'd0, cnt}, 32'd4);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("mid_rst_inc",  {31'd0, inc},  32'd0);
    check_eq("mid_rst_cnt",  {24'd0, cnt},  32'd5);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_hold", {24'd0, cnt}, 32'd5);

`ifdef LBIST_CTRL_TIMEOUT_EN
    load_cnt(8'd3);
    freeze = 1'b1;
    run("stall", 8'd3, 16'hA5C3, 1'b0, 1'b1);
    freeze = 1'b0;
    load_cnt(8'd0);
    run("after_stall", 8'd0, 16'hA5C3, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
